lsu_unit: RTL and testbench

- Load/store unit directly downstream of the instruction decoder.
- Consumes the decoder's one-hot load strobes (lb/lh/lw/ld/lbu/lhu/lwu) and store strobes (sb/sh/sw/sd), together with the EXU-computed address and store data.
- Runs a single-outstanding transaction on a 64-bit data-memory port with valid/ready requests.
- Aligns, extends and returns load data to write-back.

---
 rtl/lsu_unit_if.sv | 47 ++++
 rtl/lsu_unit.sv | 179 +++++++++++++++++
 tb/tb_lsu_unit.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_unit_if.sv
// Bundle between the load/store unit, the EXU/write-back side and data memory.
// The slave modport is the LSU's view; the master modport is its environment.
interface lsu_unit_if #(
  parameter int AW = 64,
  parameter int DW = 64
);
  logic          in_valid;
  logic          in_ready;
  logic [6:0]    ld_op;
  logic [3:0]    st_op;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic            mem_req_wen;
  logic [AW-1:0]   mem_req_addr;
  logic [DW-1:0]   mem_req_wdata;
  logic [DW/8-1:0] mem_req_wmask;
  logic            mem_rsp_valid;
  logic [DW-1:0]   mem_rsp_rdata;

  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_rdata;
  logic          out_misalign;

  modport slave (
    input  in_valid, ld_op, st_op, addr, wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    input  out_ready,
    output in_ready,
    output mem_req_valid, mem_req_wen, mem_req_addr,
    output mem_req_wdata, mem_req_wmask,
    output out_valid, out_rdata, out_misalign
  );

  modport master (
    output in_valid, ld_op, st_op, addr, wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    output out_ready,
    input  in_ready,
    input  mem_req_valid, mem_req_wen, mem_req_addr,
    input  mem_req_wdata, mem_req_wmask,
    input  out_valid, out_rdata, out_misalign
  );
endinterface

// File: rtl/lsu_unit.sv
// Single-outstanding load/store unit on a 64-bit data port.
// Decodes one-hot ops, checks alignment, lane-shifts stores, extends loads.
module lsu_unit #(
  parameter int AW = 64,
  parameter int DW = 64
) (
  input logic       clk,
  input logic       rst,
  lsu_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } state_e;

  state_e          state_q;
  logic            in_ready_q;
  logic            req_valid_q;
  logic            wen_q;
  logic [AW-1:0]   raddr_q;
  logic [DW-1:0]   wdat_q;
  logic [DW/8-1:0] mask_q;
  logic            ov_q;
  logic [DW-1:0]   rdat_q;
  logic            mis_q;
  logic            ld_q;
  logic            sx_q;
  logic [1:0]      sz_q;
  logic [2:0]      a_q;

  logic [6:0]      ld_lo;
  logic [3:0]      st_lo;
  logic            is_ld_d;
  logic            is_st_d;
  logic            sx_d;
  logic            mis_d;
  logic [1:0]      sz_d;
  logic [2:0]      a_d;
  logic [DW/8-1:0] mask_d;
  logic [DW-1:0]   wsh_d;
  logic [DW-1:0]   word;
  logic [DW-1:0]   ext;

  // x & -x isolates the lowest set strobe, giving it priority
  assign ld_lo = bus.ld_op & (~bus.ld_op + 7'd1);
  assign st_lo = bus.st_op & (~bus.st_op + 4'd1);
  assign a_d   = bus.addr[2:0];

  always_comb begin
    is_ld_d = |bus.ld_op;
    is_st_d = !is_ld_d && (|bus.st_op);
    sz_d    = 2'd0;
    sx_d    = 1'b0;
    if (is_ld_d) begin
      unique case (1'b1)
        ld_lo[0]: begin sz_d = 2'd0; sx_d = 1'b1; end
        ld_lo[1]: begin sz_d = 2'd1; sx_d = 1'b1; end
        ld_lo[2]: begin sz_d = 2'd2; sx_d = 1'b1; end
        ld_lo[3]: sz_d = 2'd3;
        ld_lo[4]: sz_d = 2'd0;
        ld_lo[5]: sz_d = 2'd1;
        ld_lo[6]: sz_d = 2'd2;
        default: ;
      endcase
    end else if (is_st_d) begin
      unique case (1'b1)
        st_lo[0]: sz_d = 2'd0;
        st_lo[1]: sz_d = 2'd1;
        st_lo[2]: sz_d = 2'd2;
        st_lo[3]: sz_d = 2'd3;
        default: ;
      endcase
    end
  end

  always_comb begin
    mis_d  = 1'b0;
    mask_d = 8'hFF;
    case (sz_d)
      2'd0: mask_d = 8'h01 << a_d;
      2'd1: begin mis_d = a_d[0];      mask_d = 8'h03 << a_d; end
      2'd2: begin mis_d = |a_d[1:0];   mask_d = 8'h0F << a_d; end
      default: mis_d = |a_d;
    endcase
  end

  assign wsh_d = bus.wdata << {a_d, 3'b000};
  assign word  = bus.mem_rsp_rdata >> {a_q, 3'b000};

  always_comb begin
    ext = word;
    case (sz_q)
      2'd0: ext = {{56{sx_q & word[7]}}, word[7:0]};
      2'd1: ext = {{48{sx_q & word[15]}}, word[15:0]};
      2'd2: ext = {{32{sx_q & word[31]}}, word[31:0]};
      default: ext = word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      req_valid_q <= 1'b0;
      wen_q       <= 1'b0;
      raddr_q     <= '0;
      wdat_q      <= '0;
      mask_q      <= '0;
      ov_q        <= 1'b0;
      rdat_q      <= '0;
      mis_q       <= 1'b0;
      ld_q        <= 1'b0;
      sx_q        <= 1'b0;
      sz_q        <= 2'd0;
      a_q         <= 3'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            in_ready_q <= 1'b0;
            ld_q       <= is_ld_d;
            sx_q       <= sx_d;
            sz_q       <= sz_d;
            a_q        <= a_d;
            if (!(is_ld_d || is_st_d) || mis_d) begin
              state_q <= DONE;
              ov_q    <= 1'b1;
              rdat_q  <= '0;
              mis_q   <= mis_d;
            end else begin
              state_q     <= REQ;
              req_valid_q <= 1'b1;
              wen_q       <= is_st_d;
              raddr_q     <= {bus.addr[AW-1:3], 3'b000};
              wdat_q      <= is_st_d ? wsh_d : '0;
              mask_q      <= is_st_d ? mask_d : '0;
            end
          end
        end
        REQ: begin
          if (bus.mem_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (bus.mem_rsp_valid) begin
            state_q <= DONE;
            ov_q    <= 1'b1;
            rdat_q  <= ld_q ? ext : '0;
            mis_q   <= 1'b0;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            ov_q       <= 1'b0;
            in_ready_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_req_wen   = wen_q;
  assign bus.mem_req_addr  = raddr_q;
  assign bus.mem_req_wdata = wdat_q;
  assign bus.mem_req_wmask = mask_q;
  assign bus.out_valid     = ov_q;
  assign bus.out_rdata     = rdat_q;
  assign bus.out_misalign  = mis_q;

endmodule

// File: tb/tb_lsu_unit.sv
// Randomized and directed bench for lsu_unit.
// Expectations come from a byte-level model of the load/store rules.
module tb_lsu_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  lsu_unit_if #(.AW(64), .DW(64)) bus ();

  lsu_unit #(.AW(64), .DW(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    bit          noop;
    bit          fault;
    bit          mem;
    bit          wen;
    logic [7:0]  mask;
    logic [63:0] wd;
    logic [63:0] res;
  } exp_t;

  typedef struct {
    bit          req;
    bit          stable;
    bit          busy_rdy;
    bit          idle_rdy;
    bit          tmo;
    int          lat;
    int          req_cyc;
    int          ov_cyc;
    logic        wen;
    logic [7:0]  mask;
    logic [63:0] addr;
    logic [63:0] wd;
    logic [63:0] res;
    logic        mis;
  } obs_t;

  function automatic exp_t model(input logic [6:0] ld, input logic [3:0] st,
                                 input logic [63:0] addr, input logic [63:0] wdata,
                                 input logic [63:0] rdata);
    exp_t e;
    int n = 0;
    int a;
    bit sgn = 0;
    bit store = 0;
    logic [63:0] v;
    logic [63:0] keep;
    e = '{default: '0};
    for (int i = 6; i >= 0; i--)
      if (ld[i]) begin
        n = 1 << (i < 4 ? i : i - 4);
        sgn = (i < 3);
      end
    if (n == 0)
      for (int i = 3; i >= 0; i--)
        if (st[i]) begin
          n = 1 << i;
          store = 1;
        end
    a = int'(addr[2:0]);
    e.noop = (n == 0);
    e.fault = !e.noop && ((a % n) != 0);
    e.mem = !e.noop && !e.fault;
    e.wen = e.mem && store;
    if (e.wen) begin
      e.mask = 8'(((1 << n) - 1) << a);
      e.wd = wdata << (8 * a);
    end
    if (e.mem && !store) begin
      v = rdata >> (8 * a);
      keep = (n == 8) ? '1 : ((64'd1 << (8 * n)) - 64'd1);
      v = v & keep;
      if (sgn && v[8 * n - 1]) v = v | ~keep;
      e.res = v;
    end
    return e;
  endfunction

  task automatic do_op(input logic [6:0] ld, input logic [3:0] st,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [63:0] rdata, input int rstall,
                       input int ostall, output obs_t o);
    int k = 0;
    int rs = 0;
    int oc = 0;
    bit hs = 0;
    bit done = 0;
    o = '{default: '0};
    o.stable = 1;
    o.idle_rdy = bus.in_ready;
    bus.in_valid = 1'b1;
    bus.ld_op = ld;
    bus.st_op = st;
    bus.addr = addr;
    bus.wdata = wdata;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.ld_op = 7'($urandom);
    bus.st_op = 4'($urandom);
    bus.addr = {$urandom, $urandom};
    bus.wdata = {$urandom, $urandom};
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
      bus.mem_rsp_valid = hs;
      bus.mem_rsp_rdata = hs ? rdata : {$urandom, $urandom};
      hs = 0;
      bus.mem_req_ready = 1'b0;
      if (bus.mem_req_valid) begin
        if (!o.req) begin
          o.req = 1;
          o.addr = bus.mem_req_addr;
          o.wen = bus.mem_req_wen;
          o.mask = bus.mem_req_wmask;
          o.wd = bus.mem_req_wdata;
        end else if (o.addr !== bus.mem_req_addr || o.wen !== bus.mem_req_wen ||
                     o.mask !== bus.mem_req_wmask || o.wd !== bus.mem_req_wdata) begin
          o.stable = 0;
        end
        o.req_cyc++;
        if (rs >= rstall) begin
          bus.mem_req_ready = 1'b1;
          hs = 1;
        end else rs++;
      end
      if (bus.out_valid) begin
        if (o.ov_cyc == 0) begin
          o.lat = k;
          o.res = bus.out_rdata;
          o.mis = bus.out_misalign;
        end else if (o.res !== bus.out_rdata || o.mis !== bus.out_misalign) begin
          o.stable = 0;
        end
        o.ov_cyc++;
        if (oc >= ostall) begin
          bus.out_ready = 1'b1;
          done = 1;
        end else oc++;
      end
      if (bus.in_ready) o.busy_rdy = 1;
    end
    o.tmo = !done;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.mem_req_valid !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: rdy=%b mreq=%b ov=%b want 1 0 0",
               bus.in_ready, bus.mem_req_valid, bus.out_valid);
    end
    checks++;
    if (bus.mem_req_wen !== 1'b0 || bus.mem_req_addr !== 64'd0 || bus.mem_req_wdata !== 64'd0 ||
        bus.mem_req_wmask !== 8'd0 || bus.out_rdata !== 64'd0 || bus.out_misalign !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: wen=%b a=%h wd=%h m=%h rd=%h mis=%b want all 0",
               bus.mem_req_wen, bus.mem_req_addr, bus.mem_req_wdata,
               bus.mem_req_wmask, bus.out_rdata, bus.out_misalign);
    end
  endtask

  task automatic test_byte_loads();
    obs_t o;
    do_op(7'b0000001, 4'b0000, 64'h8000_0003, 64'd0, 64'h1122_3344_8566_7788, 0, 0, o);
    checks++;
    if (o.addr !== 64'h8000_0000 || o.mask !== 8'h00 || o.wen !== 1'b0 || !o.req) begin
      errors++;
      $display("FAIL lb_req: addr=%h mask=%h wen=%b req=%b want 80000000 00 0 1",
               o.addr, o.mask, o.wen, o.req);
    end
    checks++;
    if (o.res !== 64'hFFFF_FFFF_FFFF_FF85 || o.lat != 3 || o.mis !== 1'b0) begin
      errors++;
      $display("FAIL lb_data: got %h lat %0d mis %b want ffffffffffffff85 3 0", o.res, o.lat, o.mis);
    end
    do_op(7'b0010000, 4'b0000, 64'h8000_0003, 64'd0, 64'h1122_3344_8566_7788, 0, 0, o);
    checks++;
    if (o.res !== 64'h85) begin
      errors++;
      $display("FAIL lbu_data: got %h want 85", o.res);
    end
  endtask

  task automatic test_half_store();
    obs_t o;
    do_op(7'b0, 4'b0010, 64'h8000_0006, 64'hABCD, {$urandom, $urandom}, 0, 0, o);
    checks++;
    if (o.wen !== 1'b1 || o.mask !== 8'hC0 || o.wd !== 64'hABCD_0000_0000_0000) begin
      errors++;
      $display("FAIL sh_req: wen=%b mask=%h wd=%h want 1 c0 abcd000000000000", o.wen, o.mask, o.wd);
    end
    checks++;
    if (o.res !== 64'd0 || o.mis !== 1'b0 || o.tmo) begin
      errors++;
      $display("FAIL sh_out: rd=%h mis=%b tmo=%b want 0 0 0", o.res, o.mis, o.tmo);
    end
  endtask

  task automatic test_misalign();
    obs_t o;
    do_op(7'b0000100, 4'b0000, 64'h8000_0002, 64'd0, 64'd0, 0, 0, o);
    checks++;
    if (o.req || o.lat != 1 || o.mis !== 1'b1 || o.res !== 64'd0) begin
      errors++;
      $display("FAIL lw_misalign: req=%b lat=%0d mis=%b rd=%h want 0 1 1 0", o.req, o.lat, o.mis, o.res);
    end
  endtask

  task automatic test_word_loads();
    obs_t o;
    do_op(7'b0000100, 4'b0000, 64'h8000_0004, 64'd0, 64'h8000_0001_DEAD_BEEF, 0, 0, o);
    checks++;
    if (o.res !== 64'hFFFF_FFFF_8000_0001) begin
      errors++;
      $display("FAIL lw_sext: got %h want ffffffff80000001", o.res);
    end
    do_op(7'b1000000, 4'b0000, 64'h8000_0004, 64'd0, 64'h8000_0001_DEAD_BEEF, 0, 0, o);
    checks++;
    if (o.res !== 64'h0000_0000_8000_0001) begin
      errors++;
      $display("FAIL lwu_zext: got %h want 0000000080000001", o.res);
    end
  endtask

  task automatic test_stall();
    obs_t o;
    logic [63:0] wd;
    wd = {$urandom, $urandom};
    do_op(7'b0, 4'b1000, 64'h8000_0010, wd, 64'd0, 3, 2, o);
    checks++;
    if (!o.stable || o.mask !== 8'hFF || o.wd !== wd || o.req_cyc != 4) begin
      errors++;
      $display("FAIL sd_stall_req: stable=%b mask=%h wd=%h cyc=%0d want 1 ff %h 4",
               o.stable, o.mask, o.wd, o.req_cyc, wd);
    end
    checks++;
    if (o.ov_cyc != 3 || o.busy_rdy || o.res !== 64'd0) begin
      errors++;
      $display("FAIL sd_stall_out: ovcyc=%0d busyrdy=%b rd=%h want 3 0 0", o.ov_cyc, o.busy_rdy, o.res);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    exp_t e;
    logic [63:0] ad;
    logic [63:0] rd;
    for (int i = 0; i < 4; i++) begin
      ad = {32'd0, 32'h8000_0000 + ($urandom_range(0, 255) << 3)};
      rd = {$urandom, $urandom};
      e = model(7'b0001000, 4'b0, ad, 64'd0, rd);
      do_op(7'b0001000, 4'b0, ad, 64'd0, rd, 0, 0, o);
      checks++;
      if (!o.idle_rdy || o.lat != 3 || o.res !== e.res) begin
        errors++;
        $display("FAIL b2b_%0d: rdy=%b lat=%0d rd=%h want 1 3 %h", i, o.idle_rdy, o.lat, o.res, e.res);
      end
    end
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    logic [6:0] ld;
    logic [3:0] st;
    logic [63:0] ad, wd, rd;
    int rsl, osl, mode, el;
    for (int i = 0; i < 60; i++) begin
      mode = $urandom_range(0, 9);
      ld = 7'b0;
      st = 4'b0;
      if (mode < 4) begin
        ld = 7'(1 << $urandom_range(0, 6));
        st = 4'($urandom);
      end else if (mode < 8) begin
        st = 4'(1 << $urandom_range(0, 3));
      end else if (mode == 8) begin
        ld = 7'($urandom);
        st = 4'($urandom);
      end
      ad = {$urandom, $urandom};
      wd = {$urandom, $urandom};
      rd = {$urandom, $urandom};
      rsl = $urandom_range(0, 2);
      osl = $urandom_range(0, 2);
      e = model(ld, st, ad, wd, rd);
      do_op(ld, st, ad, wd, rd, rsl, osl, o);
      el = e.mem ? 3 + rsl : 1;
      checks++;
      if (o.tmo || o.lat != el || o.ov_cyc != osl + 1 || !o.stable || o.busy_rdy) begin
        errors++;
        $display("FAIL rnd_flow_%0d: tmo=%b lat=%0d ov=%0d st=%b br=%b want 0 %0d %0d 1 0",
                 i, o.tmo, o.lat, o.ov_cyc, o.stable, o.busy_rdy, el, osl + 1);
      end
      checks++;
      if (o.req != e.mem || (e.mem && (o.addr !== {ad[63:3], 3'b000} || o.wen !== e.wen ||
          o.mask !== e.mask || (e.wen && o.wd !== e.wd)))) begin
        errors++;
        $display("FAIL rnd_req_%0d: req=%b a=%h wen=%b m=%h wd=%h want %b %h %b %h %h",
                 i, o.req, o.addr, o.wen, o.mask, o.wd, e.mem, {ad[63:3], 3'b000}, e.wen, e.mask, e.wd);
      end
      checks++;
      if (o.res !== e.res || o.mis !== e.fault) begin
        errors++;
        $display("FAIL rnd_out_%0d: ld=%b st=%b a=%h rd=%h mis=%b want %h %b",
                 i, ld, st, ad, o.res, o.mis, e.res, e.fault);
      end
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    bit seen = 0;
    bus.in_valid = 1'b1;
    bus.ld_op = 7'b0001000;
    bus.st_op = 4'b0;
    bus.addr = 64'h8000_0008;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    while (!bus.mem_req_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!bus.mem_req_valid) begin
      errors++;
      $display("FAIL rstmid_req: mem_req_valid=%b want 1", bus.mem_req_valid);
    end
    @(negedge clk);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_state: rdy=%b ov=%b mreq=%b want 1 0 0",
               bus.in_ready, bus.out_valid, bus.mem_req_valid);
    end
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = {$urandom, $urandom};
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    repeat (4) begin
      if (bus.out_valid) seen = 1;
      @(negedge clk);
    end
    checks++;
    if (seen || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_late_rsp: ov_seen=%b rdy=%b want 0 1", seen, bus.in_ready);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.ld_op = 7'b0;
    bus.st_op = 4'b0;
    bus.addr = 64'd0;
    bus.wdata = 64'd0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_rdata = 64'd0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_byte_loads();
    test_half_store();
    test_misalign();
    test_word_loads();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
